// File: rtl/data_ram_ctrl.sv
// ----------------------------------------------------------------------------
// data_ram_ctrl
//   Single-port data RAM behind the CPU data port. It provides registered loads
//   with one cycle of latency, stores that complete at their own edge, and a
//   full-memory clear sweep that runs one word per cycle.
//
//   Optional feature macro: DATA_RAM_WRPROT_EN
//     When this macro is defined, the top 256 words are read-only. Stores to
//     those words are discarded, and werr pulses for one cycle afterwards. The
//     clear sweep skips those words but still takes the same number of cycles.
//     When the macro is undefined, every word is writable and werr stays 0.
//
//   Ports
//     clk    : clock; all state changes on the rising edge
//     reset  : asynchronous, active-high reset (memory contents untouched)
//     sel    : access request strobe
//     ld     : 1 = load, 0 = store (qualified by sel)
//     clr    : start (or restart) a full-memory clear sweep
//     addr   : word address of the access
//     wdata  : store data
//     rdata  : registered load data, holds until the next load
//     rvalid : one-cycle pulse, rdata updated this cycle
//     busy   : clear sweep in progress, accesses ignored
//     werr   : one-cycle pulse, store rejected by write protection
// ----------------------------------------------------------------------------
module data_ram_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              ld,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              werr
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              doLoad;
    logic              doStore;
    logic              storeProt;
    logic              ptrProt;
    logic              sweepStep;
    logic              memWe;
    logic [ADDR_W-1:0] memWaddr;
    logic [DATA_W-1:0] memWdata;

    // A clr request takes priority over sel, and accesses are ignored during a sweep.
    assign accept    = (state == IDLE) && sel && !clr;
    assign doLoad    = accept && ld;
    assign doStore   = accept && !ld;
    assign sweepStep = (state == CLEAR) && !clr;

`ifdef DATA_RAM_WRPROT_EN
    localparam logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(DEPTH - 256);
    assign storeProt = (addr >= PROT_BASE);
    assign ptrProt   = (ptr  >= PROT_BASE);
`else
    assign storeProt = 1'b0;
    assign ptrProt   = 1'b0;
`endif

    // A single write port is shared by CPU stores and the clear sweep. The two
    // sources are mutually exclusive because stores are accepted only in IDLE.
    always_comb begin
        memWe    = 1'b0;
        memWaddr = addr;
        memWdata = wdata;
        if (sweepStep) begin
            memWe    = !ptrProt;
            memWaddr = ptr;
            memWdata = '0;
        end else if (doStore) begin
            memWe    = !storeProt;
        end
    end

    // The memory array has no reset, so a reset never disturbs stored words.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memWaddr] <= memWdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= doLoad;
            if (doLoad) begin
                rdata <= mem[addr];
            end

            if (clr) begin
                state <= CLEAR;
                ptr   <= '0;
            end else if (state == CLEAR) begin
                // The pointer stops at the last word instead of wrapping.
                if (ptr == LAST_ADDR) begin
                    state <= IDLE;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
        end
    end

`ifdef DATA_RAM_WRPROT_EN
    logic werrReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            werrReg <= 1'b0;
        end else begin
            werrReg <= doStore && storeProt;
        end
    end

    assign werr = werrReg;
`else
    assign werr = 1'b0;
`endif

    assign busy = (state == CLEAR);

endmodule
